// File: rtl/hd63701_phase_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : hd63701_phase_seq_if
// Description : Bundles the signals between the HD63701 microcode/datapath
//               and the phase sequencer.
//               master : microcode/datapath side. It drives the step requests,
//                        the instruction qualifiers, the CCR I mask and the
//                        interrupt sources.
//               slave  : the sequencer. It drives phase, vec_sel, set_i,
//                        int_ack and halted.
//               The mc_slp qualifier is present only when HD63701_SLP_EN
//               is defined.
// Ports       : ce, mc_next, mc_end, mc_swi, mc_trap, mc_wai, [mc_slp],
//               iflag, nmi, irq_req[N_IRQ], phase[6], vec_sel[4], set_i,
//               int_ack[N_IRQ], halted
// Revision    : 1.0 - initial release
// ============================================================================
interface hd63701_phase_seq_if #(
    parameter int N_IRQ = 5
);
    logic             ce;
    logic             mc_next;
    logic             mc_end;
    logic             mc_swi;
    logic             mc_trap;
    logic             mc_wai;
`ifdef HD63701_SLP_EN
    logic             mc_slp;
`endif
    logic             iflag;
    logic             nmi;
    logic [N_IRQ-1:0] irq_req;
    logic [5:0]       phase;
    logic [3:0]       vec_sel;
    logic             set_i;
    logic [N_IRQ-1:0] int_ack;
    logic             halted;

    modport master (
        output ce, mc_next, mc_end, mc_swi, mc_trap, mc_wai,
`ifdef HD63701_SLP_EN
        output mc_slp,
`endif
        output iflag, nmi, irq_req,
        input  phase, vec_sel, set_i, int_ack, halted
    );

    modport slave (
        input  ce, mc_next, mc_end, mc_swi, mc_trap, mc_wai,
`ifdef HD63701_SLP_EN
        input  mc_slp,
`endif
        input  iflag, nmi, irq_req,
        output phase, vec_sel, set_i, int_ack, halted
    );
endinterface
`default_nettype wire

// File: rtl/hd63701_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : hd63701_phase_seq
// Description : Phase sequencer and interrupt scheduler for the HD63701 core.
//               - Produces the 6-bit microcode phase code:
//                   RST 0x00, VECT 0x01, VEC1 0x02, VEC2 0x03,
//                   EXEC0-9 0x10-0x19, INTR0-7 0x20-0x27,
//                   INTR8 (WAIT) 0x28, INTR9 (SLEEP) 0x29, HALT 0x3F.
//               - Arbitrates TRAP, SWI, NMI and the maskable sources at
//                 instruction boundaries.
//               - Latches the vector index for the datapath.
// Ports       : clk     - core clock
//               rst_n   - asynchronous active-low reset
//               bus     - hd63701_phase_seq_if.slave:
//                         ce, mc_* qualifiers, iflag, nmi and irq_req in;
//                         phase, vec_sel, set_i, int_ack and halted out
// Options     : HD63701_SLP_EN - adds the mc_slp qualifier and the SLEEP
//               state (phase INTR9).
// Revision    : 1.0 - initial release
// ============================================================================
module hd63701_phase_seq #(
    parameter int N_IRQ = 5     // must match the interface; 3+N_IRQ-1 < 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    hd63701_phase_seq_if.slave  bus
);

    localparam logic [5:0] c_PH_RST   = 6'h00;
    localparam logic [5:0] c_PH_VECT  = 6'h01;
    localparam logic [5:0] c_PH_VEC1  = 6'h02;
    localparam logic [5:0] c_PH_VEC2  = 6'h03;
    localparam logic [5:0] c_PH_INTR8 = 6'h28;
    localparam logic [5:0] c_PH_INTR9 = 6'h29;
    localparam logic [5:0] c_PH_HALT  = 6'h3F;

    localparam logic [3:0] c_VEC_NMI  = 4'd1;
    localparam logic [3:0] c_VEC_SWI  = 4'd2;
    localparam logic [3:0] c_VEC_TRAP = 4'd8;

    typedef enum logic [3:0] {
        ST_RST   = 4'd0,
        ST_VECT  = 4'd1,
        ST_VEC1  = 4'd2,
        ST_VEC2  = 4'd3,
        ST_EXEC  = 4'd4,
        ST_INTR  = 4'd5,
        ST_WAIT  = 4'd6,
`ifdef HD63701_SLP_EN
        ST_SLEEP = 4'd7,
`endif
        ST_HALT  = 4'd8
    } state_t;

    state_t           r_state;
    logic [3:0]       r_step;       // EXECn / INTRn index
    logic [3:0]       r_vec;
    logic             r_wai;        // push sequence belongs to a WAI
    logic             r_nmi_pend;
    logic             r_nmi_prev;
    logic [5:0]       r_phase;
    logic             r_set_i;
    logic [N_IRQ-1:0] r_ack;
    logic             r_halted;

    state_t           w_nxt_state;
    logic [3:0]       w_nxt_step;
    logic [3:0]       w_nxt_vec;
    logic             w_nxt_wai;
    logic             w_nmi_rise;
    logic             w_nmi_now;
    logic             w_irq_any;
    logic             w_unmasked;
    logic [3:0]       w_irq_vec;
    logic             w_vect_entry;
    logic [N_IRQ-1:0] w_ack;

    function automatic logic [5:0] phase_code(input state_t st, input logic [3:0] step);
        case (st)
            ST_RST:   phase_code = c_PH_RST;
            ST_VECT:  phase_code = c_PH_VECT;
            ST_VEC1:  phase_code = c_PH_VEC1;
            ST_VEC2:  phase_code = c_PH_VEC2;
            ST_EXEC:  phase_code = {2'b01, step};
            ST_INTR:  phase_code = {2'b10, step};
            ST_WAIT:  phase_code = c_PH_INTR8;
`ifdef HD63701_SLP_EN
            ST_SLEEP: phase_code = c_PH_INTR9;
`endif
            ST_HALT:  phase_code = c_PH_HALT;
            default:  phase_code = c_PH_RST;
        endcase
    endfunction

    // Request qualification and the lowest-index maskable source.
    // An NMI edge arriving in the decision cycle already counts as pending.
    always_comb begin
        w_nmi_rise = bus.nmi & ~r_nmi_prev;
        w_nmi_now  = r_nmi_pend | w_nmi_rise;
        w_irq_any  = |bus.irq_req;
        w_unmasked = w_irq_any & ~bus.iflag;
        w_irq_vec  = 4'd0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (bus.irq_req[k]) begin
                w_irq_vec = 4'(3 + k);
            end
        end
    end

    // Next-state decision
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_step  = r_step;
        w_nxt_vec   = r_vec;
        w_nxt_wai   = r_wai;
        case (r_state)
            ST_RST:  w_nxt_state = ST_VECT;
            ST_VECT: w_nxt_state = ST_VEC1;
            ST_VEC1: w_nxt_state = ST_VEC2;
            ST_VEC2: begin
                w_nxt_state = ST_EXEC;
                w_nxt_step  = 4'd0;
            end
            ST_EXEC: begin
                if (bus.mc_end) begin
                    w_nxt_step = 4'd0;
                    if (bus.mc_trap) begin
                        w_nxt_state = ST_INTR;
                        w_nxt_vec   = c_VEC_TRAP;
                    end else if (bus.mc_swi) begin
                        w_nxt_state = ST_INTR;
                        w_nxt_vec   = c_VEC_SWI;
                    end else if (bus.mc_wai) begin
                        // The vector is chosen later, when WAIT is left
                        w_nxt_state = ST_INTR;
                        w_nxt_wai   = 1'b1;
`ifdef HD63701_SLP_EN
                    end else if (bus.mc_slp) begin
                        w_nxt_state = ST_SLEEP;
`endif
                    end else if (w_nmi_now) begin
                        w_nxt_state = ST_INTR;
                        w_nxt_vec   = c_VEC_NMI;
                    end else if (w_unmasked) begin
                        w_nxt_state = ST_INTR;
                        w_nxt_vec   = w_irq_vec;
                    end else begin
                        w_nxt_state = ST_EXEC;
                    end
                end else if (bus.mc_next) begin
                    if (r_step == 4'd9) begin
                        w_nxt_state = ST_HALT;
                    end else begin
                        w_nxt_step = r_step + 4'd1;
                    end
                end
            end
            ST_INTR: begin
                if (r_step == 4'd7) begin
                    w_nxt_state = r_wai ? ST_WAIT : ST_VECT;
                end else begin
                    w_nxt_step = r_step + 4'd1;
                end
            end
            ST_WAIT: begin
                // Registers were pushed already, so go straight to the vector
                if (w_nmi_now) begin
                    w_nxt_state = ST_VECT;
                    w_nxt_vec   = c_VEC_NMI;
                    w_nxt_wai   = 1'b0;
                end else if (w_unmasked) begin
                    w_nxt_state = ST_VECT;
                    w_nxt_vec   = w_irq_vec;
                    w_nxt_wai   = 1'b0;
                end
            end
`ifdef HD63701_SLP_EN
            ST_SLEEP: begin
                w_nxt_step = 4'd0;
                if (w_nmi_now) begin
                    w_nxt_state = ST_INTR;
                    w_nxt_vec   = c_VEC_NMI;
                end else if (w_unmasked) begin
                    w_nxt_state = ST_INTR;
                    w_nxt_vec   = w_irq_vec;
                end else if (w_irq_any) begin
                    // Masked source only wakes the core, no service
                    w_nxt_state = ST_EXEC;
                end
            end
`endif
            ST_HALT: w_nxt_state = ST_HALT;
            default: w_nxt_state = ST_RST;
        endcase
    end

    // VECT lasts one cycle, so a next state of VECT is always an entry
    always_comb begin
        w_vect_entry = (w_nxt_state == ST_VECT);
        for (int k = 0; k < N_IRQ; k++) begin
            w_ack[k] = w_vect_entry && (w_nxt_vec == 4'(3 + k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RST;
            r_step     <= 4'd0;
            r_vec      <= 4'd0;
            r_wai      <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_nmi_prev <= 1'b1;
            r_phase    <= c_PH_RST;
            r_set_i    <= 1'b0;
            r_ack      <= '0;
            r_halted   <= 1'b0;
        end else if (bus.ce) begin
            r_state    <= w_nxt_state;
            r_step     <= w_nxt_step;
            r_vec      <= w_nxt_vec;
            r_wai      <= w_nxt_wai;
            r_nmi_prev <= bus.nmi;
            r_phase    <= phase_code(w_nxt_state, w_nxt_step);
            r_set_i    <= (w_nxt_state == ST_VEC2);
            r_ack      <= w_ack;
            r_halted   <= (w_nxt_state == ST_HALT);
            // A new edge wins over the acknowledge in the same cycle
            if (w_nmi_rise) begin
                r_nmi_pend <= 1'b1;
            end else if (w_vect_entry && (w_nxt_vec == c_VEC_NMI)) begin
                r_nmi_pend <= 1'b0;
            end
        end
    end

    assign bus.phase   = r_phase;
    assign bus.vec_sel = r_vec;
    assign bus.set_i   = r_set_i;
    assign bus.int_ack = r_ack;
    assign bus.halted  = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_hd63701_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hd63701_phase_seq
// Description : Self-checking bench for hd63701_phase_seq. Expected phase
//               traces come from the instruction-level rules (push sequence,
//               vector priority) rather than from the sequencer's states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hd63701_phase_seq;

    localparam logic [5:0] PH_RST   = 6'h00;
    localparam logic [5:0] PH_VECT  = 6'h01;
    localparam logic [5:0] PH_VEC1  = 6'h02;
    localparam logic [5:0] PH_VEC2  = 6'h03;
    localparam logic [5:0] PH_EXEC  = 6'h10;
    localparam logic [5:0] PH_INTR  = 6'h20;
    localparam logic [5:0] PH_INTR8 = 6'h28;
    localparam logic [5:0] PH_HALT  = 6'h3F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [5:0] oph[$];
    logic [3:0] ovec[$];
    logic       oseti[$];
    logic [4:0] oack[$];
    logic       ohalt[$];

    always #5 clk = ~clk;

    hd63701_phase_seq_if #(.N_IRQ(5)) bus ();

    hd63701_phase_seq #(.N_IRQ(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.ce      = 1'b1;
        bus.mc_next = 1'b0;
        bus.mc_end  = 1'b0;
        bus.mc_swi  = 1'b0;
        bus.mc_trap = 1'b0;
        bus.mc_wai  = 1'b0;
`ifdef HD63701_SLP_EN
        bus.mc_slp  = 1'b0;
`endif
    endtask

    task automatic clear_obs();
        oph.delete(); ovec.delete(); oseti.delete(); oack.delete(); ohalt.delete();
    endtask

    // One clock; outputs recorded 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        oph.push_back(bus.phase);
        ovec.push_back(bus.vec_sel);
        oseti.push_back(bus.set_i);
        oack.push_back(bus.int_ack);
        ohalt.push_back(bus.halted);
    endtask

    // Reference priority: -1 means no service, next opcode
    function automatic int pick_vec(bit trap, bit swi, bit nmi_p, logic [4:0] irq, bit ifl);
        if (trap)  return 8;
        if (swi)   return 2;
        if (nmi_p) return 1;
        if (!ifl) begin
            for (int k = 0; k < 5; k++) if (irq[k]) return 3 + k;
        end
        return -1;
    endfunction

    // Phase expected i cycles after a servicing boundary (i=0 is INTR0)
    function automatic logic [5:0] svc_phase(int i);
        if (i < 8)   return 6'(PH_INTR + i);
        if (i == 8)  return PH_VECT;
        if (i == 9)  return PH_VEC1;
        if (i == 10) return PH_VEC2;
        return PH_EXEC;
    endfunction

    task automatic test_reset();
        logic [5:0] exp_ph [4];
        int nset;
        exp_ph = '{PH_VECT, PH_VEC1, PH_VEC2, PH_EXEC};
        rst_n = 1'b0;
        idle_inputs();
        bus.iflag = 1'b0; bus.nmi = 1'b0; bus.irq_req = '0;
        tick(); tick();
        checks++;
        if (bus.phase !== PH_RST || bus.vec_sel !== 4'd0 || bus.set_i !== 1'b0 ||
            bus.int_ack !== 5'd0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got ph=%h vec=%0d seti=%b ack=%b halt=%b expected ph=00 vec=0 seti=0 ack=0 halt=0",
                     bus.phase, bus.vec_sel, bus.set_i, bus.int_ack, bus.halted);
        end
        rst_n = 1'b1;
        clear_obs();
        repeat (4) tick();
        nset = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (oph[i] !== exp_ph[i] || ovec[i] !== 4'd0) begin
                failures++;
                $display("FAIL reset_seq[%0d]: got ph=%h vec=%0d expected ph=%h vec=0", i, oph[i], ovec[i], exp_ph[i]);
            end
            if (oseti[i]) nset++;
        end
        checks++;
        if (nset != 1 || oseti[2] !== 1'b1) begin
            failures++;
            $display("FAIL reset_seti: got %0d pulses (at VEC2=%b) expected 1 at VEC2", nset, oseti[2]);
        end
    endtask

    task automatic test_exec_step();
        for (int rep = 0; rep < 3; rep++) begin
            int n;
            n = (rep == 0) ? 3 : int'($urandom_range(1, 9));
            for (int i = 1; i <= n; i++) begin
                bus.mc_next = 1'b1;
                tick();
                checks++;
                if (oph[$] !== 6'(PH_EXEC + i)) begin
                    failures++;
                    $display("FAIL exec_step: got %h expected %h", oph[$], 6'(PH_EXEC + i));
                end
                if ($urandom_range(0, 1) == 1) begin
                    bus.mc_next = 1'b0;
                    tick();
                    checks++;
                    if (oph[$] !== 6'(PH_EXEC + i)) begin
                        failures++;
                        $display("FAIL exec_hold: got %h expected %h", oph[$], 6'(PH_EXEC + i));
                    end
                end
            end
            // MC_END wins over a simultaneous MC_NEXT
            bus.mc_next = 1'($urandom_range(0, 1));
            bus.mc_end  = 1'b1;
            tick();
            idle_inputs();
            checks++;
            if (oph[$] !== PH_EXEC || oack[$] !== 5'd0) begin
                failures++;
                $display("FAIL exec_end: got ph=%h ack=%b expected ph=%h ack=0", oph[$], oack[$], PH_EXEC);
            end
        end
    endtask

    task automatic test_irq_random();
        for (int it = 0; it < 10; it++) begin
            logic [4:0] irq;
            bit ifl, trap, swi;
            int v;
            logic [4:0] eack;
            irq  = 5'($urandom_range(1, 31));
            ifl  = 1'($urandom_range(0, 1));
            trap = ($urandom_range(0, 5) == 0);
            swi  = ($urandom_range(0, 5) == 0);
            if (it < 2) begin
                irq = 5'b01010; ifl = (it == 1); trap = 0; swi = 0;
            end
            v = pick_vec(trap, swi, 1'b0, irq, ifl);
            bus.irq_req = irq; bus.iflag = ifl;
            bus.mc_trap = trap; bus.mc_swi = swi; bus.mc_end = 1'b1;
            clear_obs();
            tick();
            idle_inputs();
            if ($urandom_range(0, 1) == 1) bus.irq_req = '0;  // latched vector must survive
            if (v < 0) begin
                checks++;
                if (oph[0] !== PH_EXEC || oack[0] !== 5'd0) begin
                    failures++;
                    $display("FAIL irq_none: got ph=%h ack=%b expected ph=%h ack=0", oph[0], oack[0], PH_EXEC);
                end
            end else begin
                repeat (11) tick();
                eack = (v >= 3) ? 5'(1 << (v - 3)) : 5'd0;
                for (int i = 0; i < 12; i++) begin
                    checks++;
                    if (oph[i] !== svc_phase(i) || ovec[i] !== 4'(v) ||
                        oseti[i] !== (i == 10) || oack[i] !== ((i == 8) ? eack : 5'd0)) begin
                        failures++;
                        $display("FAIL irq_svc[%0d] v=%0d: got ph=%h vec=%0d seti=%b ack=%b expected ph=%h vec=%0d seti=%b ack=%b",
                                 i, v, oph[i], ovec[i], oseti[i], oack[i], svc_phase(i), v, (i == 10),
                                 (i == 8) ? eack : 5'd0);
                    end
                end
            end
            bus.irq_req = '0;
        end
    endtask

    task automatic test_nmi_irq();
        bus.iflag = 1'b0;
        bus.irq_req = 5'b00001;
        bus.nmi = 1'b1;
        bus.mc_end = 1'b1;
        clear_obs();
        tick();
        idle_inputs();
        repeat (11) tick();
        bus.nmi = 1'b0;
        checks++;
        if (oph[8] !== PH_VECT || ovec[8] !== 4'd1 || oack[8] !== 5'd0 || oph[11] !== PH_EXEC) begin
            failures++;
            $display("FAIL nmi_first: got ph=%h vec=%0d ack=%b end=%h expected ph=01 vec=1 ack=0 end=%h",
                     oph[8], ovec[8], oack[8], oph[11], PH_EXEC);
        end
        // Pending must be gone: the still-active IRQ1 is next
        bus.mc_end = 1'b1;
        clear_obs();
        tick();
        idle_inputs();
        repeat (11) tick();
        checks++;
        if (oph[8] !== PH_VECT || ovec[8] !== 4'd3 || oack[8] !== 5'b00001) begin
            failures++;
            $display("FAIL nmi_then_irq: got ph=%h vec=%0d ack=%b expected ph=01 vec=3 ack=00001",
                     oph[8], ovec[8], oack[8]);
        end
        bus.irq_req = '0;
        // Two edges before service collapse into one service
        bus.nmi = 1'b1; tick(); bus.nmi = 1'b0; tick();
        bus.nmi = 1'b1; tick(); bus.nmi = 1'b0; tick();
        bus.mc_end = 1'b1;
        clear_obs();
        tick();
        idle_inputs();
        repeat (11) tick();
        checks++;
        if (ovec[8] !== 4'd1 || oph[8] !== PH_VECT) begin
            failures++;
            $display("FAIL nmi_collapse_svc: got ph=%h vec=%0d expected ph=01 vec=1", oph[8], ovec[8]);
        end
        bus.mc_end = 1'b1;
        clear_obs();
        tick();
        idle_inputs();
        checks++;
        if (oph[0] !== PH_EXEC) begin
            failures++;
            $display("FAIL nmi_collapse_once: got ph=%h expected %h", oph[0], PH_EXEC);
        end
    endtask

    task automatic test_wai();
        bus.iflag = 1'b0; bus.irq_req = '0; bus.nmi = 1'b0;
        bus.mc_end = 1'b1; bus.mc_wai = 1'b1;
        clear_obs();
        tick();
        idle_inputs();
        repeat (27) begin
            if (oph.size() == 23) begin
                bus.iflag = 1'b1; bus.irq_req = 5'b00010;   // masked: must not wake
            end
            tick();
        end
        for (int i = 0; i < 28; i++) begin
            logic [5:0] ep;
            ep = (i < 8) ? 6'(PH_INTR + i) : PH_INTR8;
            checks++;
            if (oph[i] !== ep) begin
                failures++;
                $display("FAIL wai_hold[%0d]: got %h expected %h", i, oph[i], ep);
            end
        end
        bus.iflag = 1'b0; bus.irq_req = 5'b10000;
        tick();
        bus.irq_req = '0;
        tick(); tick(); tick();
        checks++;
        if (oph[28] !== PH_VECT || ovec[28] !== 4'd7 || oack[28] !== 5'b10000) begin
            failures++;
            $display("FAIL wai_wake: got ph=%h vec=%0d ack=%b expected ph=01 vec=7 ack=10000",
                     oph[28], ovec[28], oack[28]);
        end
        checks++;
        if (oph[29] !== PH_VEC1 || oph[30] !== PH_VEC2 || oseti[30] !== 1'b1 || oph[31] !== PH_EXEC) begin
            failures++;
            $display("FAIL wai_tail: got %h %h seti=%b %h expected 02 03 seti=1 %h",
                     oph[29], oph[30], oseti[30], oph[31], PH_EXEC);
        end
    endtask

    task automatic test_ce();
        bus.ce = 1'b0; bus.mc_next = 1'b1;
        clear_obs();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (oph[i] !== PH_EXEC) begin
                failures++;
                $display("FAIL ce_hold[%0d]: got %h expected %h", i, oph[i], PH_EXEC);
            end
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        bus.mc_next = 1'b1;
        clear_obs();
        repeat (10) tick();
        bus.mc_next = 1'b0; bus.mc_end = 1'b1;
        repeat (3) tick();
        idle_inputs();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (oph[i] !== 6'(PH_EXEC + i + 1) || ohalt[i] !== 1'b0) begin
                failures++;
                $display("FAIL halt_steps[%0d]: got ph=%h halt=%b expected ph=%h halt=0",
                         i, oph[i], ohalt[i], 6'(PH_EXEC + i + 1));
            end
        end
        for (int i = 9; i < 13; i++) begin
            checks++;
            if (oph[i] !== PH_HALT || ohalt[i] !== 1'b1) begin
                failures++;
                $display("FAIL halt_state[%0d]: got ph=%h halt=%b expected ph=3f halt=1", i, oph[i], ohalt[i]);
            end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.phase !== PH_RST || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_async_reset: got ph=%h halt=%b expected ph=00 halt=0", bus.phase, bus.halted);
        end
        tick();
        rst_n = 1'b1;
        clear_obs();
        repeat (4) tick();
        checks++;
        if (oph[3] !== PH_EXEC) begin
            failures++;
            $display("FAIL halt_restart: got %h expected %h", oph[3], PH_EXEC);
        end
    endtask

    initial begin
        test_reset();
        test_exec_step();
        test_irq_random();
        test_nmi_irq();
        test_wai();
        test_ce();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/hd63701_phase_seq.md
Name: hd63701_phase_seq

Overview:
- Phase sequencer and interrupt scheduler for the HD63701 core.
- Generates the 6-bit PHASE code that selects microcode rows: reset vector fetch, vector load, EXEC0-9 instruction steps, and the INTR0-7 register-push sequence.
- Arbitrates reset, TRAP, SWI, NMI and the maskable sources at instruction boundaries, and tells the datapath which vector to load.

Parameters:
- N_IRQ, 5, number of maskable sources. Index 0=IRQ1, 1=ICF, 2=OCF, 3=TOF, 4=SCI; lower index has higher priority.

Ports:
- CLK  in  1  core clock
- RSTn  in  1  asynchronous active-low reset
- CE  in  1  clock enable; all state holds when low
- MC_NEXT  in  1  microcode requests the next EXEC step
- MC_END  in  1  microcode marks the last step of the instruction
- MC_SWI  in  1  qualifies MC_END: instruction is SWI
- MC_TRAP  in  1  qualifies MC_END: illegal opcode
- MC_WAI  in  1  qualifies MC_END: instruction is WAI
- IFLAG  in  1  CCR I mask
- NMI  in  1  NMI pin, already synchronised, rising-edge sensitive
- IRQ_REQ  in  N_IRQ  level requests from the maskable sources
- PHASE  out  6  phase code using the shared ph* defines
- VEC_SEL  out  4  vector index: 0 RESET, 1 NMI, 2 SWI, 3+k IRQ_REQ[k], 8 TRAP
- SET_I  out  1  one-cycle pulse: datapath sets the I mask
- INT_ACK  out  N_IRQ  one-hot, one-cycle acknowledge of the serviced maskable source
- HALTED  out  1  high while PHASE = HALT

Behaviour:
- Reset (RSTn low, async): PHASE=phRST, VEC_SEL=0, SET_I=0, INT_ACK=0, HALTED=0, NMI pending cleared, WAI flag cleared, edge detector's previous-NMI register=1.
- All transitions occur only on CLK edges with CE=1. All outputs are registered.
- Reset and vector path: phRST -> phVECT -> phVEC1 -> phVEC2 -> phEXEC. One cycle each. SET_I pulses in the cycle PHASE enters phVEC2.
- EXEC stepping:
  - phEXEC(n) with MC_NEXT and not MC_END -> phEXEC(n+1).
  - MC_NEXT in phEXEC9 -> HALT (PHASE = MC_HALT code, HALTED=1). Only reset exits HALT.
  - MC_END has priority over MC_NEXT.
  - Neither asserted: hold the current phase.
- Boundary decision, made at MC_END in any EXECn, priority high to low:
  - MC_TRAP -> vector 8
  - MC_SWI -> vector 2
  - NMI pending -> vector 1
  - lowest index k with IRQ_REQ[k]=1 and IFLAG=0 -> vector 3+k
  - otherwise -> phEXEC, next opcode
- On selecting a vector, VEC_SEL is latched and PHASE goes to phINTR. INTR..INTR7 advance one per cycle, then phVECT, phVEC1, phVEC2, phEXEC. VEC_SEL is stable from the decision until phEXEC entry.
- WAI (MC_END with MC_WAI and no TRAP/SWI):
  - Runs INTR..INTR7 with the WAI flag set.
  - After INTR7, enters WAIT (PHASE = phINTR8) and holds.
  - Exits when NMI pending, or when any IRQ_REQ is set with IFLAG=0. Vector is chosen by the normal priority, then phVECT with no second push.
- Acknowledge:
  - NMI pending is set on a rising NMI edge and cleared on entry to phVECT with VEC_SEL=1. An edge in that same cycle keeps it set.
  - INT_ACK[k] pulses on entry to phVECT with VEC_SEL=3+k.
- IRQ_REQ deasserting after the decision does not cancel the service; the latched vector is used.
- Multiple simultaneous NMI edges before service collapse to one.

Optional Feature:
- Macro HD63701_SLP_EN. When defined, adds input MC_SLP, which qualifies MC_END.
  - MC_END with MC_SLP enters SLEEP (PHASE = phINTR9) with no pushes.
  - Wakes on NMI pending, or on any IRQ_REQ set.
  - Unmasked (or NMI): normal INTR push sequence with the selected vector.
  - Masked IRQ only (IFLAG=1): resumes at phEXEC, next instruction.
- When not defined: no MC_SLP port, no SLEEP state.

Test Plan:
- Release RSTn -> PHASE sequence RST, VECT, VEC1, VEC2, EXEC on 5 consecutive edges; VEC_SEL=0; SET_I pulses once at VEC2.
- MC_NEXT x3 then MC_END, no requests -> EXEC1, EXEC2, EXEC3, then EXEC; INT_ACK=0.
- IRQ_REQ=5'b01010, IFLAG=0, MC_END -> INTR..INTR7, VECT with VEC_SEL=4; INT_ACK=5'b00010 on VECT entry. Repeat with IFLAG=1 -> straight back to EXEC.
- NMI edge plus IRQ_REQ[0] at the same MC_END -> VEC_SEL=1; NMI pending cleared. The next MC_END services VEC_SEL=3.
- MC_END with MC_WAI, no requests -> after INTR7 PHASE holds at INTR8 for 20 cycles. IRQ_REQ[4] with IFLAG=0 -> VECT next edge, VEC_SEL=7, no extra INTR phases.
- 10 consecutive MC_NEXT from EXEC -> HALT, HALTED=1; RSTn pulse low mid-HALT -> PHASE=phRST asynchronously.
